// File: rtl/scarv_cop_rng_pool.sv
// Coprocessor RNG with a shift-left XNOR LFSR, a background-filled sample pool and RSEED/RSAMP/RTEST service.
// Optional health monitor (lock/repetition faults) is built when SCARV_COP_RNG_POOL_HEALTH_EN is defined.
module scarv_cop_rng_pool #(
    parameter int                LFSR_W          = 32,
    parameter logic [LFSR_W-1:0] TAPS            = 32'h80200003,
    parameter int                DEPTH           = 4,
    parameter logic [LFSR_W-1:0] RNG_RESET_VALUE = '0,
    parameter int                REP_LIMIT       = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        rng_ivalid,
    output logic        rng_idone,
    input  logic [31:0] rng_rs1,
    input  logic [31:0] id_imm,
    input  logic [14:0] id_subclass,
    output logic [3:0]  rng_cpr_rd_ben,
    output logic [31:0] rng_cpr_rd_wdata
);

    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [LFSR_W-1:0] ALL_ONES = '1;

    localparam int SCLASS_RSEED = 0;
    localparam int SCLASS_RTEST = 1;
    localparam int SCLASS_RSAMP = 2;

    logic [LFSR_W-1:0] state_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [31:0]       pool_mem [DEPTH];

    logic              do_rseed;
    logic              do_rsamp;
    logic              do_rtest;
    logic              fb;
    logic [LFSR_W-1:0] adv_state;
    logic [LFSR_W-1:0] seed_state;
    logic [31:0]       sample;
    logic              state_locked;
    logic              pool_empty;
    logic              fault;
    logic              gen_push;
    logic              pool_pop;
    logic              lock_fault;
    logic              rep_fault;
    logic              health_flush;
    logic              unused_inputs;

    assign unused_inputs = ^{id_imm, id_subclass[14:3]};

    // Only one instruction is decoded; RSEED outranks RSAMP, which outranks RTEST.
    assign do_rseed = rng_ivalid & id_subclass[SCLASS_RSEED];
    assign do_rsamp = rng_ivalid & ~id_subclass[SCLASS_RSEED] & id_subclass[SCLASS_RSAMP];
    assign do_rtest = rng_ivalid & ~id_subclass[SCLASS_RSEED] & ~id_subclass[SCLASS_RSAMP]
                    & id_subclass[SCLASS_RTEST];

    assign fb        = ~(^(state_reg & TAPS));
    assign adv_state = {state_reg[LFSR_W-2:0], fb};
    assign sample    = adv_state[31:0];

    generate
        if (LFSR_W == 32) begin : g_seed_narrow
            assign seed_state = rng_rs1;
        end else begin : g_seed_wide
            assign seed_state = {state_reg[LFSR_W-33:0], rng_rs1};
        end
    endgenerate

    assign state_locked = (state_reg == ALL_ONES);
    assign pool_empty   = (count_reg == '0);
    assign fault        = lock_fault | rep_fault;
    // All-ones is the XNOR LFSR fixed point, so generation stops there even without health logic.
    assign gen_push     = (count_reg < DEPTH_C) & ~fault & ~state_locked & ~do_rseed;
    assign pool_pop     = do_rsamp & ~pool_empty & ~fault;

`ifdef SCARV_COP_RNG_POOL_HEALTH_EN
    logic        lock_fault_reg;
    logic        rep_fault_reg;
    logic [7:0]  rep_cnt_reg;
    logic [7:0]  rep_cnt_next;
    logic [31:0] last_sample_reg;
    logic        lock_hit;
    logic        rep_hit;

    assign rep_cnt_next = (sample == last_sample_reg) ? rep_cnt_reg + 8'd1 : 8'd1;
    assign rep_hit      = gen_push & (rep_cnt_next == 8'(REP_LIMIT));
    assign lock_hit     = state_locked & ~do_rseed;
    assign health_flush = lock_hit | rep_hit;
    assign lock_fault   = lock_fault_reg;
    assign rep_fault    = rep_fault_reg;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_fault_reg  <= 1'b0;
            rep_fault_reg   <= 1'b0;
            rep_cnt_reg     <= 8'd0;
            last_sample_reg <= 32'd0;
        end else if (do_rseed) begin
            lock_fault_reg <= 1'b0;
            rep_fault_reg  <= 1'b0;
            rep_cnt_reg    <= 8'd0;
        end else begin
            if (lock_hit) begin
                lock_fault_reg <= 1'b1;
            end
            if (rep_hit) begin
                rep_fault_reg <= 1'b1;
            end
            if (gen_push) begin
                rep_cnt_reg     <= rep_cnt_next;
                last_sample_reg <= sample;
            end
        end
    end
`else
    assign lock_fault   = 1'b0;
    assign rep_fault    = 1'b0;
    assign health_flush = 1'b0;
`endif

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_reg <= RNG_RESET_VALUE;
        end else if (do_rseed) begin
            state_reg <= seed_state;
        end else if (gen_push) begin
            state_reg <= adv_state;
        end
    end

    // A flush (RSEED or a fresh fault) discards both the same-cycle push and pop.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (do_rseed || health_flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (gen_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pool_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({gen_push, pool_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (gen_push) begin
            pool_mem[wr_ptr_reg] <= sample;
        end
    end

    always_comb begin
        rng_idone        = 1'b0;
        rng_cpr_rd_ben   = 4'b0000;
        rng_cpr_rd_wdata = 32'd0;
        if (g_resetn) begin
            if (do_rseed) begin
                rng_idone = 1'b1;
            end else if (do_rsamp) begin
                if (fault) begin
                    rng_idone = 1'b1;
                end else if (!pool_empty) begin
                    rng_idone        = 1'b1;
                    rng_cpr_rd_ben   = 4'b1111;
                    rng_cpr_rd_wdata = pool_mem[rd_ptr_reg];
                end
            end else if (do_rtest) begin
                rng_idone        = 1'b1;
                rng_cpr_rd_wdata = {16'd0, 8'(count_reg), 5'd0, rep_fault, lock_fault, ~fault};
            end
        end
    end

endmodule
